// File: rtl/ysyx_220066_mem_pkg.sv
// Shared address map and region decode for the memory-side responder.
package ysyx_220066_mem_pkg;

  localparam logic [63:0] RAM_BASE    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SERIAL_ADDR = 64'h0000_0000_a000_03f8;
  localparam logic [63:0] RTC_ADDR    = 64'h0000_0000_a000_0048;

  typedef enum logic [1:0] {REG_RAM, REG_SERIAL, REG_RTC, REG_NONE} region_e;

  // RAM_BASE and the RAM size are multiples of 8, so the byte offset never changes the RAM verdict.
  function automatic region_e decode(input logic [63:0] a, input int ram_aw);
    if (a[63:3] == SERIAL_ADDR[63:3]) return REG_SERIAL;
    if (a[63:3] == RTC_ADDR[63:3])    return REG_RTC;
    if ((a >= RAM_BASE) && (((a - RAM_BASE) >> ram_aw) == 64'd0)) return REG_RAM;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/ysyx_220066_txfifo.sv
// Serial TX byte FIFO: pointer/count queue with a sticky drop flag.
module ysyx_220066_txfifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop_ready,
  output logic [7:0] dout,
  output logic       valid,
  output logic       overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          full, pop, push_ok;

  assign valid   = (count != '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign pop     = valid && pop_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign dout    = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ysyx_220066_memsys.sv
// Zero-latency memory responder for the single-cycle core: RAM, serial TX, microsecond timer.
module ysyx_220066_memsys
  import ysyx_220066_mem_pkg::*;
#(
  parameter int RAM_AW     = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_PER_US = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc,
  output logic [63:0] instr_data,
  input  logic [63:0] addr,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [63:0] data_Wr_data,
  output logic [63:0] data_Rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        access_fault,
  output logic        tx_overflow
);

  localparam int WORDS = 2 ** (RAM_AW - 3);
  localparam int PW    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [63:0] ram [WORDS];
  region_e     d_reg, i_reg;
  logic        d_acc;
  logic [PW-1:0] presc;
  logic [63:0]   timer;
  logic          tick;

  assign d_reg = decode(addr, RAM_AW);
  assign i_reg = decode(pc, RAM_AW);
  assign d_acc = MemRd || MemWr;

  always_comb begin
    instr_data = 64'd0;
    if (i_reg == REG_RAM) instr_data = ram[pc[RAM_AW-1:3]];
  end

  // Data is also returned on MemWr: the core merges partial stores from it.
  always_comb begin
    data_Rd_data = 64'd0;
    if (d_acc) begin
      case (d_reg)
        REG_RAM: data_Rd_data = ram[addr[RAM_AW-1:3]];
        REG_RTC: data_Rd_data = timer;
        default: data_Rd_data = 64'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && MemWr && (d_reg == REG_RAM)) ram[addr[RAM_AW-1:3]] <= data_Wr_data;
  end

  assign tick = (presc == PW'(CLK_PER_US - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      timer <= 64'd0;
    end else if (tick) begin
      presc <= '0;
      timer <= timer + 64'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      access_fault <= 1'b0;
    end else if ((d_acc && (d_reg == REG_NONE)) || (i_reg != REG_RAM)) begin
      access_fault <= 1'b1;
    end
  end

  ysyx_220066_txfifo #(.DEPTH(FIFO_DEPTH)) u_txfifo (
    .clk      (clk),
    .rst      (rst),
    .push     (MemWr && (d_reg == REG_SERIAL)),
    .din      (data_Wr_data[7:0]),
    .pop_ready(tx_ready),
    .dout     (tx_data),
    .valid    (tx_valid),
    .overflow (tx_overflow)
  );

endmodule

// File: tb/tb_ysyx_220066_memsys.sv
// Directed self-checking bench for the memory responder.
module tb_ysyx_220066_memsys;

  localparam logic [63:0] SER = 64'h0000_0000_a000_03f8;
  localparam logic [63:0] RTC = 64'h0000_0000_a000_0048;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc, instr_data, addr, data_Wr_data, data_Rd_data;
  logic        MemRd, MemWr;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, access_fault, tx_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_220066_memsys #(.RAM_AW(16), .FIFO_DEPTH(8), .CLK_PER_US(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .instr_data  (instr_data),
    .addr        (addr),
    .MemRd       (MemRd),
    .MemWr       (MemWr),
    .data_Wr_data(data_Wr_data),
    .data_Rd_data(data_Rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .access_fault(access_fault),
    .tx_overflow (tx_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ser_wr(input logic [7:0] b);
    addr = SER; MemWr = 1'b1; data_Wr_data = {56'd0, b};
    step();
    MemWr = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = 64'h8000_0000; addr = 64'h8000_0000;
    MemRd = 1'b0; MemWr = 1'b0; data_Wr_data = 64'd0; tx_ready = 1'b0;
    step(); step();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_fault", access_fault, 0);
    check("rst_overflow", tx_overflow, 0);
    rst = 1'b0;

    // RAM write, same-cycle old value, next-cycle new value, fetch view
    addr = 64'h8000_0010; MemWr = 1'b1; data_Wr_data = 64'haaaa_bbbb_cccc_dddd;
    step();
    data_Wr_data = 64'h1122_3344_5566_7788;
    #1 check("ram_old_on_wr", data_Rd_data, 64'haaaa_bbbb_cccc_dddd);
    step();
    MemWr = 1'b0; MemRd = 1'b1;
    #1 check("ram_rd_new", data_Rd_data, 64'h1122_3344_5566_7788);
    pc = 64'h8000_0014;
    #1 check("ram_fetch", instr_data, 64'h1122_3344_5566_7788);
    MemRd = 1'b0;
    #1 check("rd_idle_zero", data_Rd_data, 0);
    addr = SER; MemRd = 1'b1;
    #1 check("serial_rd_zero", data_Rd_data, 0);
    MemRd = 1'b0;

    // serial burst under backpressure
    ser_wr(8'h48);
    check("hi_valid_rise", tx_valid, 1);
    ser_wr(8'h69);
    step(); step();
    check("hi_hold_valid", tx_valid, 1);
    check("hi_hold_data", tx_data, 8'h48);
    tx_ready = 1'b1;
    #1 check("hi_first", tx_data, 8'h48);
    step();
    check("hi_second", tx_data, 8'h69);
    check("hi_second_valid", tx_valid, 1);
    step();
    check("hi_empty", tx_valid, 0);
    tx_ready = 1'b0;

    // overflow: ninth byte dropped
    for (int i = 0; i < 9; i++) ser_wr(8'(i));
    check("ovf_flag", tx_overflow, 1);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_drain%0d", i), tx_data, 64'(i));
      step();
    end
    check("ovf_drained", tx_valid, 0);
    tx_ready = 1'b0;

    // full FIFO with simultaneous pop accepts the push
    pulse_rst();
    check("ovf_cleared", tx_overflow, 0);
    for (int i = 0; i < 8; i++) ser_wr(8'(8'h10 + i));
    tx_ready = 1'b1;
    ser_wr(8'h18);
    check("full_pop_no_ovf", tx_overflow, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_pop_drain%0d", i), tx_data, 64'(8'h11 + i));
      step();
    end
    check("full_pop_empty", tx_valid, 0);
    tx_ready = 1'b0;

    // timer: 40 cycles at 4 clk/us -> 10
    pulse_rst();
    repeat (40) step();
    addr = RTC; MemRd = 1'b1;
    #1 check("rtc_10", data_Rd_data, 10);
    MemRd = 1'b0; MemWr = 1'b1; data_Wr_data = 64'hdead;
    step();
    MemWr = 1'b0; MemRd = 1'b1;
    #1 check("rtc_wr_ignored", data_Rd_data, 10);
    check("rtc_no_fault", access_fault, 0);
    MemRd = 1'b0;

    // unmapped data read
    addr = 64'h1000; MemRd = 1'b1;
    #1 check("unmapped_rd_zero", data_Rd_data, 0);
    check("fault_not_yet", access_fault, 0);
    step();
    MemRd = 1'b0;
    check("fault_set", access_fault, 1);
    step(); step();
    check("fault_sticky", access_fault, 1);
    pulse_rst();
    check("fault_cleared", access_fault, 0);

    // unmapped fetch
    pc = 64'h0;
    #1 check("bad_pc_instr_zero", instr_data, 0);
    step();
    pc = 64'h8000_0000;
    check("pc_fault", access_fault, 1);
    pulse_rst();
    check("pc_fault_cleared", access_fault, 0);

    // reset mid-drain flushes the FIFO
    ser_wr(8'h31); ser_wr(8'h32); ser_wr(8'h33);
    check("queued_valid", tx_valid, 1);
    pulse_rst();
    check("flush_valid", tx_valid, 0);
    check("flush_data", tx_data, 0);
    ser_wr(8'h41);
    check("post_flush_data", tx_data, 8'h41);
    tx_ready = 1'b1;
    step();
    check("post_flush_only", tx_valid, 0);
    tx_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_memsys.md
Name: ysyx_220066_memsys

Overview:
Memory-side responder for the single-cycle RV64 core's fetch and data interface; sits outside the core top in the simulation/SoC shell. Serves:
- 64-bit instruction doublewords, indexed by pc.
- Full-doubleword data reads and writes. The core has already byte-merged write data.
- Two MMIO devices: a serial TX port with an 8-entry byte FIFO, and a microsecond timer.
- A sticky access-fault flag for unmapped accesses.

Parameters:
RAM_AW, 24, log2 of RAM size in bytes; RAM occupies [RAM_BASE, RAM_BASE + 2^RAM_AW).
FIFO_DEPTH, 8, serial TX FIFO entries; power of two, at least 2.
CLK_PER_US, 100, clk cycles per timer tick; at least 1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
pc  in  64  fetch address; bits [2:0] ignored
instr_data  out  64  doubleword at pc aligned down to 8
addr  in  64  data address; bits [2:0] ignored for selection
MemRd  in  1  data read strobe
MemWr  in  1  data write strobe; commits at the rising edge
data_Wr_data  in  64  fully merged doubleword to store
data_Rd_data  out  64  doubleword at addr aligned down to 8
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  sink accepts the head byte this cycle
access_fault  out  1  sticky: an unmapped data access or fetch occurred
tx_overflow  out  1  sticky: a serial byte was dropped because the FIFO was full

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Every state element uses clk and rst.
- Reset values:
  - FIFO empty, so tx_valid=0; tx_data=0.
  - Timer=0, prescaler=0.
  - access_fault=0, tx_overflow=0.
  - RAM contents are not reset.
- Address map (decode on addr[63:3]):
  - RAM: RAM_BASE=0x8000_0000.
  - SERIAL: 0xa000_03f8.
  - RTC: 0xa000_0048.
  - Everything else is unmapped.
- Reads (combinational, zero latency; required because the core is single-cycle):
  - instr_data = RAM[pc index] when pc is in RAM, else 0.
  - data_Rd_data when MemRd=1 or MemWr=1:
    - RAM hit: the RAM doubleword.
    - RTC: the 64-bit timer.
    - SERIAL: 0.
    - Unmapped: 0.
  - data_Rd_data=0 when neither strobe is high.
  - Reason for returning data on MemWr: the core merges partial stores using data_Rd_data, so data_Rd_data must be valid whenever MemWr=1.
- Writes (at the rising edge when MemWr=1 and rst=0):
  - RAM hit: the doubleword is replaced by data_Wr_data.
  - SERIAL: push data_Wr_data[7:0].
  - RTC: writes are ignored.
  - Same-cycle read of the address being written returns the old value; the new value is visible from the next cycle.
- Faults:
  - A MemRd or MemWr to an unmapped address sets access_fault at the next edge; an unmapped write has no effect.
  - A pc outside RAM also sets access_fault.
  - access_fault is cleared only by rst.
  - MemRd and MemWr both high is legal and is treated as a write.
- TX FIFO:
  - Implemented with read/write pointers and a count.
  - Pop when tx_valid && tx_ready.
  - Push accepted when count<FIFO_DEPTH, or when full and a pop occurs in the same cycle.
  - Push while full with no pop: the byte is dropped and tx_overflow is set (sticky).
  - Push into an empty FIFO: tx_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data is the head entry (registered storage) and is held stable while tx_valid && !tx_ready.
- Timer:
  - The prescaler counts 0..CLK_PER_US-1. On wrap, the timer increments by 1.
  - The 64-bit timer wraps naturally.
  - When CLK_PER_US=1, the timer increments every cycle.
- Reset mid-operation: the FIFO is flushed (pending bytes are lost) and both sticky flags clear. Any write in a cycle with rst=1 is suppressed.

Decomposition:
- Package ysyx_220066_mem_pkg holds:
  - the address constants RAM_BASE, SERIAL_ADDR, RTC_ADDR;
  - a region enum {REG_RAM, REG_SERIAL, REG_RTC, REG_NONE};
  - the decode function addr -> region.
- Sub-module ysyx_220066_txfifo (parameter DEPTH):
  - inputs: push, din[7:0], pop_ready;
  - outputs: dout, valid, overflow.
- The top instantiates the RAM array, the decode, the timer and the FIFO.

Test Plan:
1. RAM write then read: write 0x1122334455667788 to 0x8000_0010; same cycle data_Rd_data=old value; next cycle MemRd -> 0x1122334455667788. pc=0x8000_0014 -> instr_data equals the same doubleword.
2. Serial burst with backpressure:
   - With tx_ready=0, write 'H','i' to 0xa000_03f8.
   - tx_valid=1 and tx_data=0x48 stay held.
   - Raise tx_ready: 0x48 then 0x69 appear on consecutive cycles, then tx_valid=0.
3. FIFO overflow:
   - With tx_ready=0, write 9 bytes 0x00..0x08. Byte 0x08 is dropped, tx_overflow=1, and the drain yields 0x00..0x07.
   - Separately, with the FIFO full, a push with tx_ready=1 is accepted and tx_overflow stays 0.
4. Timer: CLK_PER_US=4, release reset, read 0xa000_0048 after 40 cycles -> 10. A write of 0xdead to the RTC does not change the timer.
5. Fault: MemRd at 0x0000_1000 -> data_Rd_data=0, and access_fault=1 next cycle and stays 1. rst high for one cycle -> access_fault=0.
6. Reset mid-drain: 3 bytes queued, assert rst for one cycle -> tx_valid=0 the cycle after; a subsequent write of 0x41 emits only 0x41.
